cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped cache controller sitting between the CPU request port and the 8-line × 8-bit cache data memory. It keeps the tag and valid arrays, issues read and write commands to the data memory, and fetches from or writes through to main memory over a req/ack handshake. Write policy is write-through. A write hit updates both cache and memory; a write miss writes memory only, with no allocation.

## Interface
- TAG_W, 3, tag width; CPU address is TAG_W+3 bits, index = cpu_addr[2:0], tag = cpu_addr[TAG_W+2:3]
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  TAG_W+3  request address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data; holds last read result, unchanged by writes
- cpu_ready  out  1  one-cycle completion pulse
- cm_addr  out  3  data-memory line index
- cm_rd  out  1  data-memory read; cm_rdata is valid in the cycle after cm_rd
- cm_wr  out  1  data-memory write; the memory captures cm_wdata on the negedge of the same cycle
- cm_wdata  out  8  data-memory write data
- cm_rdata  in  8  data-memory registered read data
- mm_req  out  1  main-memory request, held until ack
- mm_wr  out  1  main-memory write when 1
- mm_addr  out  TAG_W+3  main-memory address (latched request address)
- mm_wdata  out  8  main-memory write data
- mm_rdata  in  8  main-memory read data, valid with mm_ack
- mm_ack  in  1  main-memory completion, one-cycle pulse
- hit_cnt  out  8  lookup hits, saturating at 255
- miss_cnt  out  8  lookup misses, saturating at 255

## Operation
- State machine: IDLE, CHECK, RHIT, MREQ, FILL, WMEM, RESP. Outputs are Moore, decoded from state and latched request registers.
- IDLE: on cpu_req=1, latch addr/wr/wdata and go to CHECK. Requests in any other state are ignored.
- CHECK: hit = valid[idx] && tag[idx]==req_tag. The matching counter increments here, saturating.
  - Read hit: cm_rd=1, cm_addr=idx, go to RHIT.
  - Read miss: go to MREQ.
  - Write: if hit, cm_wr=1, cm_addr=idx, cm_wdata=req_wdata. In both cases go to WMEM.
- RHIT: cpu_rdata <= cm_rdata, go to RESP.
- MREQ: mm_req=1, mm_wr=0. When mm_ack is sampled, capture mm_rdata into fill_data and go to FILL.
- FILL: cm_wr=1, cm_addr=idx, cm_wdata=fill_data. Set tag[idx] <= req_tag, valid[idx] <= 1, cpu_rdata <= fill_data, go to RESP.
- WMEM: mm_req=1, mm_wr=1, mm_wdata=req_wdata. On mm_ack go to RESP. Tag and valid are unchanged.
- RESP: cpu_ready=1, go to IDLE.
- mm_ack outside MREQ/WMEM is ignored. mm_req drops in the cycle after ack is sampled.
- mm_addr always equals the latched request address.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; tags 0
  - cpu_rdata, cpu_ready 0
  - cm_* 0
  - mm_req, mm_wr, mm_addr, mm_wdata 0
  - hit_cnt, miss_cnt 0
- Reset mid-transaction (any state) returns to IDLE immediately and abandons any pending main-memory access. mm_req deasserts asynchronously.
- Read hit: request accepted at edge t0; cpu_ready is high in the cycle after edge t2, i.e. 3 cycles.
- Read miss: cpu_ready follows 4 cycles after acceptance plus the ack wait. With mm_ack in the first MREQ cycle, the total is 4.
- Write: 3 cycles plus the ack wait.
- Back-to-back requests: the next request can be accepted no earlier than the IDLE cycle following RESP.
- A cm_wr from CHECK or FILL completes at that cycle's negedge. A read of the same line in the next request returns the new data.

## Test plan
- Reset, then read 0x0D (tag 1, idx 5); mm_rdata=0xA5 with ack after 2 wait cycles -> mm_addr=0x0D, cm_wr at idx 5 with 0xA5, cpu_rdata=0xA5, miss_cnt=1.
- Read 0x0D again -> cm_rd at idx 5, no mm_req, cpu_ready 3 cycles after accept, cpu_rdata=0xA5, hit_cnt=1.
- Conflict: read 0x15 (tag 2, idx 5) with mm_rdata=0x5A -> miss and refill. Then read 0x0D -> miss again, miss_cnt=3.
- Write hit to 0x15 with 0x3C -> cm_wr at idx 5 with 0x3C and mm write 0x15/0x3C; the following read of 0x15 hits and returns 0x3C. Write miss to 0x20 with 0x77 -> no cm_wr; the following read of 0x20 misses.
- Assert rst while in MREQ -> mm_req=0 immediately, all outputs at reset values. A following read of 0x0D misses.
- Issue 300 read hits -> hit_cnt saturates at 255 without wrapping. Toggle cpu_req while busy -> no extra transactions.

Source files
------------

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through cache controller: 8 lines of 8-bit data, tag/valid arrays,
// external data memory and main memory over a req/ack handshake.
module cache_ctrl #(
    parameter int TAG_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [TAG_W+2:0]   cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_ready,
    output logic [2:0]         cm_addr,
    output logic               cm_rd,
    output logic               cm_wr,
    output logic [7:0]         cm_wdata,
    input  logic [7:0]         cm_rdata,
    output logic               mm_req,
    output logic               mm_wr,
    output logic [TAG_W+2:0]   mm_addr,
    output logic [7:0]         mm_wdata,
    input  logic [7:0]         mm_rdata,
    input  logic               mm_ack,
    output logic [7:0]         hit_cnt,
    output logic [7:0]         miss_cnt
);
    localparam int AW = TAG_W + 3;

    typedef enum logic [2:0] {IDLE, CHECK, RHIT, MREQ, FILL, WMEM, RESP} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             hit_q, hit_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       fill_q, fill_d;
    logic [7:0]       cpu_rdata_q, cpu_rdata_d;
    logic             cpu_ready_q, cpu_ready_d;
    logic             cm_rd_q, cm_rd_d;
    logic             cm_wr_q, cm_wr_d;
    logic [7:0]       cm_wdata_q, cm_wdata_d;
    logic             mm_req_q, mm_req_d;
    logic             mm_wr_q, mm_wr_d;
    logic [7:0]       hit_cnt_q, hit_cnt_d;
    logic [7:0]       miss_cnt_q, miss_cnt_d;
    logic [TAG_W-1:0] tag_q [8];
    logic [TAG_W-1:0] tag_d [8];
    logic [7:0]       valid_q, valid_d;

    logic [2:0]       cpu_idx, req_idx;
    logic [TAG_W-1:0] cpu_tag, req_tag;
    logic             lookup_hit;

    assign cpu_idx = cpu_addr[2:0];
    assign cpu_tag = cpu_addr[AW-1:3];
    assign req_idx = addr_q[2:0];
    assign req_tag = addr_q[AW-1:3];

    // Tags only change in FILL, so the lookup done while accepting in IDLE equals the one in CHECK;
    // doing it a cycle early lets every CHECK output come straight from a flop.
    assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cm_addr   = req_idx;
    assign cm_rd     = cm_rd_q;
    assign cm_wr     = cm_wr_q;
    assign cm_wdata  = cm_wdata_q;
    assign mm_req    = mm_req_q;
    assign mm_wr     = mm_wr_q;
    assign mm_addr   = addr_q;
    assign mm_wdata  = wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        // NOTE: every _d signal gets a default before the case, so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        hit_d       = hit_q;
        wdata_d     = wdata_q;
        fill_d      = fill_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cm_rd_d     = 1'b0;
        cm_wr_d     = 1'b0;
        cm_wdata_d  = 8'h00;
        mm_req_d    = 1'b0;
        mm_wr_d     = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        tag_d       = tag_q;
        valid_d     = valid_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d    = CHECK;
                    addr_d     = cpu_addr;
                    wr_d       = cpu_wr;
                    wdata_d    = cpu_wdata;
                    hit_d      = lookup_hit;
                    cm_rd_d    = !cpu_wr && lookup_hit;
                    cm_wr_d    = cpu_wr && lookup_hit;
                    cm_wdata_d = (cpu_wr && lookup_hit) ? cpu_wdata : 8'h00;
                end
            end
            CHECK: begin
                if (hit_q) begin
                    if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
                end else begin
                    if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
                end
                if (wr_q) begin
                    state_d  = WMEM;
                    mm_req_d = 1'b1;
                    mm_wr_d  = 1'b1;
                end else if (hit_q) begin
                    state_d = RHIT;
                end else begin
                    state_d  = MREQ;
                    mm_req_d = 1'b1;
                end
            end
            RHIT: begin
                cpu_rdata_d = cm_rdata;
                cpu_ready_d = 1'b1;
                state_d     = RESP;
            end
            MREQ: begin
                if (mm_ack) begin
                    fill_d     = mm_rdata;
                    cm_wr_d    = 1'b1;
                    cm_wdata_d = mm_rdata;
                    state_d    = FILL;
                end else begin
                    mm_req_d = 1'b1;
                end
            end
            FILL: begin
                tag_d[req_idx]   = req_tag;
                valid_d[req_idx] = 1'b1;
                cpu_rdata_d      = fill_q;
                cpu_ready_d      = 1'b1;
                state_d          = RESP;
            end
            WMEM: begin
                if (mm_ack) begin
                    cpu_ready_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    mm_req_d = 1'b1;
                    mm_wr_d  = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            hit_q       <= 1'b0;
            wdata_q     <= 8'h00;
            fill_q      <= 8'h00;
            cpu_rdata_q <= 8'h00;
            cpu_ready_q <= 1'b0;
            cm_rd_q     <= 1'b0;
            cm_wr_q     <= 1'b0;
            cm_wdata_q  <= 8'h00;
            mm_req_q    <= 1'b0;
            mm_wr_q     <= 1'b0;
            hit_cnt_q   <= 8'h00;
            miss_cnt_q  <= 8'h00;
            valid_q     <= 8'h00;
            // NOTE: tag/valid are small flop arrays, not RAM, so they can and must clear on reset.
            for (int i = 0; i < 8; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            hit_q       <= hit_d;
            wdata_q     <= wdata_d;
            fill_q      <= fill_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cm_rd_q     <= cm_rd_d;
            cm_wr_q     <= cm_wr_d;
            cm_wdata_q  <= cm_wdata_d;
            mm_req_q    <= mm_req_d;
            mm_wr_q     <= mm_wr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: data/main memory models plus a transaction-level
// reference model of a direct-mapped write-through cache.
module tb_cache_ctrl;
    localparam int TAG_W = 3;
    localparam int AW    = TAG_W + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic [2:0]    cm_addr;
    logic          cm_rd, cm_wr;
    logic [7:0]    cm_wdata, cm_rdata;
    logic          mm_req, mm_wr;
    logic [AW-1:0] mm_addr;
    logic [7:0]    mm_wdata, mm_rdata;
    logic          mm_ack;
    logic [7:0]    hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cm_addr(cm_addr), .cm_rd(cm_rd), .cm_wr(cm_wr), .cm_wdata(cm_wdata), .cm_rdata(cm_rdata),
        .mm_req(mm_req), .mm_wr(mm_wr), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_ack(mm_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        if (a == 'h0D) return 8'hA5;
        if (a == 'h15) return 8'h5A;
        return 8'((a * 73 + 29) ^ 8'h3C);
    endfunction

    // ---------------- environment: memories and event logs ----------------
    int            mm_wait = 0;
    int            cm_wr_n = 0, cm_rd_n = 0, mm_n = 0, mm_req_cyc = 0;
    logic [2:0]    cm_wr_addr = '0, cm_rd_addr = '0;
    logic [7:0]    cm_wr_data = '0;
    logic          mm_log_wr = 1'b0;
    logic [AW-1:0] mm_log_addr = '0;
    logic [7:0]    mm_log_wdata = '0;

    initial begin : cmem_model
        logic [7:0] cmem [8];
        bit         rd_pend;
        logic [2:0] rd_a;
        rd_pend  = 1'b0;
        rd_a     = '0;
        cm_rdata = 8'h00;
        for (int i = 0; i < 8; i++) cmem[i] = 8'($urandom);
        forever begin
            @(negedge clk);
            // registered read: data appears only in the cycle after cm_rd, garbage otherwise
            if (rd_pend) cm_rdata = cmem[rd_a];
            else         cm_rdata = 8'($urandom);
            rd_pend = cm_rd && !rst;
            rd_a    = cm_addr;
            if (cm_rd) begin cm_rd_n++; cm_rd_addr = cm_addr; end
            if (cm_wr) begin
                cmem[cm_addr] = cm_wdata;
                cm_wr_n++;
                cm_wr_addr = cm_addr;
                cm_wr_data = cm_wdata;
            end
            if (mm_req) mm_req_cyc++;
        end
    end

    initial begin : mm_model
        logic [7:0] env_mem [64];
        bit         busy;
        int         wcnt;
        busy     = 1'b0;
        wcnt     = 0;
        mm_ack   = 1'b0;
        mm_rdata = 8'h00;
        for (int i = 0; i < 64; i++) env_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                mm_ack = 1'b0;
                busy   = 1'b0;
            end else if (mm_ack) begin
                mm_ack   = 1'b0;
                busy     = 1'b0;
                mm_rdata = 8'($urandom);
            end else if (mm_req) begin
                if (!busy) begin busy = 1'b1; wcnt = mm_wait; end
                if (wcnt == 0) begin
                    mm_ack = 1'b1;
                    mm_n++;
                    mm_log_wr    = mm_wr;
                    mm_log_addr  = mm_addr;
                    mm_log_wdata = mm_wdata;
                    if (mm_wr) env_mem[mm_addr] = mm_wdata;
                    else       mm_rdata = env_mem[mm_addr];
                end else begin
                    wcnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    bit         ref_valid [8];
    logic [2:0] ref_tag   [8];
    logic [7:0] ref_data  [8];
    logic [7:0] ref_mem   [64];
    logic [7:0] ref_rdata;
    int         ref_hits, ref_misses;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        ref_rdata  = 8'h00;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, ".cpu_rdata"}, cpu_rdata, 0);
        check({p, ".cpu_ready"}, cpu_ready, 0);
        check({p, ".cm_rd"},     cm_rd,     0);
        check({p, ".cm_wr"},     cm_wr,     0);
        check({p, ".cm_addr"},   cm_addr,   0);
        check({p, ".cm_wdata"},  cm_wdata,  0);
        check({p, ".mm_req"},    mm_req,    0);
        check({p, ".mm_wr"},     mm_wr,     0);
        check({p, ".mm_addr"},   mm_addr,   0);
        check({p, ".mm_wdata"},  mm_wdata,  0);
        check({p, ".hit_cnt"},   hit_cnt,   0);
        check({p, ".miss_cnt"},  miss_cnt,  0);
    endtask

    // One CPU transaction, issued in IDLE; noise=1 wiggles the CPU inputs while busy.
    task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [7:0] wdata,
                       input int wt, input bit noise);
        int         idx, lat, c_cmwr, c_cmrd, c_mm, c_req;
        logic [2:0] tg;
        bit         hit;
        int         exp_lat, exp_mm, exp_cmwr, exp_cmrd;
        logic [7:0] exp_cmwr_data;
        idx = int'(addr[2:0]);
        tg  = addr[AW-1:3];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_lat       = wr ? 3 + wt : (hit ? 3 : 4 + wt);
        exp_mm        = (!wr && hit) ? 0 : 1;
        exp_cmwr      = wr ? int'(hit) : int'(!hit);
        exp_cmrd      = (!wr && hit) ? 1 : 0;
        exp_cmwr_data = wr ? wdata : ref_mem[addr];
        if (hit) ref_hits   = (ref_hits   < 255) ? ref_hits + 1   : 255;
        else     ref_misses = (ref_misses < 255) ? ref_misses + 1 : 255;
        if (wr) begin
            ref_mem[addr] = wdata;
            if (hit) ref_data[idx] = wdata;
        end else if (hit) begin
            ref_rdata = ref_data[idx];
        end else begin
            ref_rdata      = ref_mem[addr];
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_data[idx]  = ref_mem[addr];
        end

        c_cmwr = cm_wr_n; c_cmrd = cm_rd_n; c_mm = mm_n; c_req = mm_req_cyc;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; mm_wait = wt;
        lat = 0;
        while (lat <= 100) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) break;
            cpu_req = noise ? 1'($urandom) : 1'b0;
            if (noise) begin cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom); end
        end
        cpu_req = 1'b0;

        check("latency",  lat,                  exp_lat);
        check("rdata",    cpu_rdata,            ref_rdata);
        check("hit_cnt",  hit_cnt,              ref_hits);
        check("miss_cnt", miss_cnt,             ref_misses);
        check("mm_txns",  mm_n - c_mm,          exp_mm);
        check("mm_req_cycles", mm_req_cyc - c_req, exp_mm ? wt + 1 : 0);
        check("cm_wr_n",  cm_wr_n - c_cmwr,     exp_cmwr);
        check("cm_rd_n",  cm_rd_n - c_cmrd,     exp_cmrd);
        if (exp_mm != 0) begin
            check("mm_addr", mm_log_addr, addr);
            check("mm_wr",   mm_log_wr,   wr);
            if (wr) check("mm_wdata", mm_log_wdata, wdata);
        end
        if (exp_cmwr != 0) begin
            check("cm_wr_addr", cm_wr_addr, idx);
            check("cm_wr_data", cm_wr_data, exp_cmwr_data);
        end
        if (exp_cmrd != 0) check("cm_rd_addr", cm_rd_addr, idx);
    endtask

    initial begin : stimulus
        int waited;
        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 8; i++) ref_data[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // directed scenarios
        txn(0, 6'h0D, 8'h00, 2, 0);   // miss, fill 0xA5
        txn(0, 6'h0D, 8'h00, 0, 0);   // hit
        txn(0, 6'h15, 8'h00, 1, 0);   // conflict miss, 0x5A
        txn(0, 6'h0D, 8'h00, 0, 0);   // miss again
        check("miss_cnt_after_conflict", miss_cnt, 3);
        txn(0, 6'h15, 8'h00, 0, 0);   // make 0x15 resident
        txn(1, 6'h15, 8'h3C, 1, 0);   // write hit
        txn(0, 6'h15, 8'h00, 0, 0);   // hit returns 0x3C
        check("read_after_write_hit", cpu_rdata, 8'h3C);
        txn(1, 6'h20, 8'h77, 0, 0);   // write miss, no allocate
        txn(0, 6'h20, 8'h00, 3, 0);   // read miss
        check("read_after_write_miss", cpu_rdata, 8'h77);

        // reset in the middle of a main-memory read
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 6'h2D; mm_wait = 30;
        @(negedge clk);
        cpu_req = 1'b0;
        waited = 0;
        while (!mm_req && waited < 10) begin @(negedge clk); waited++; end
        check("mm_req_before_reset", mm_req, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        txn(0, 6'h0D, 8'h00, 0, 0);
        check("miss_after_reset", miss_cnt, 1);

        // random mix over two tags per line
        for (int i = 0; i < 80; i++)
            txn(($urandom_range(0, 9) < 3), {3'($urandom_range(0, 1)), 3'($urandom)},
                8'($urandom), $urandom_range(0, 3), (i % 5 == 0));

        // hit counter saturation, with CPU input noise on some transactions
        txn(0, 6'h0D, 8'h00, 0, 0);
        for (int i = 0; i < 300; i++) txn(0, 6'h0D, 8'h00, 0, (i % 7 == 0));
        check("hit_cnt_saturated", hit_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
